// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - main control FSM and decoders for the multi-cycle RV32I datapath
//
// Sequences one instruction per 2-5 clocks (lw, sw, R-type, I-ALU, beq, jal) and drives every
// datapath select/enable. Optional feature macro: CTRL_BNE_EN (accept bne, funct3 001).
//
// Ports:
//   clk         system clock, all state on rising edge
//   reset       asynchronous active-high reset, state -> FETCH
//   instr       instruction register contents from the datapath
//   zero1       ALU zero flag, used only in the BEQ state
//   PCwrite     PC load enable (PCupdate | Branch & taken)
//   Adrsrc      memory address select (0 PC, 1 result)
//   Memwrite    data memory write enable
//   IRwrite     instruction/oldPC register load
//   ALUsrcA     ALU A select (00 PC, 01 oldPC, 10 reg A)
//   ALUsrcB     ALU B select (00 reg B, 01 immExt, 10 const 4)
//   Resultsrc   result select (00 ALUout, 01 mem data, 10 ALUresult)
//   immsrc      immediate format (00 I, 01 S, 10 B, 11 J)
//   Regwrite    register file write enable
//   ALUcontrol  ALU operation code
//   illegal     one-cycle pulse in DECODE for an unsupported opcode/funct3
//   state       current FSM state code (debug)
module multicycle_control_unit #(
    parameter int DBG_STATE_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            instr,
    input  logic                   zero1,
    output logic                   PCwrite,
    output logic                   Adrsrc,
    output logic                   Memwrite,
    output logic                   IRwrite,
    output logic [1:0]             ALUsrcA,
    output logic [1:0]             ALUsrcB,
    output logic [1:0]             Resultsrc,
    output logic [1:0]             immsrc,
    output logic                   Regwrite,
    output logic [3:0]             ALUcontrol,
    output logic                   illegal,
    output logic [DBG_STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    typedef struct packed {
        logic       adrsrc;
        logic       memwrite;
        logic       irwrite;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] resultsrc;
        logic       regwrite;
        logic [1:0] aluop;
        logic       branch;
        logic       pcupdate;
    } ctl_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1000;

    state_t     cur;
    state_t     nxt;
    ctl_t       ctl;
    logic [6:0] op;
    logic [2:0] f3;
    logic       branch_ok;
    logic       bad_instr;
    logic       taken;
    logic       unused_instr;

    assign op = instr[6:0];
    assign f3 = instr[14:12];
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

    // Moore select/enable values that belong to each state.
    function automatic ctl_t ctl_of(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH:    begin c.irwrite = 1'b1; c.srcb = 2'b10; c.resultsrc = 2'b10; c.pcupdate = 1'b1; end
            S_DECODE:   begin c.srca = 2'b01; c.srcb = 2'b01; end
            S_MEMADR:   begin c.srca = 2'b10; c.srcb = 2'b01; end
            S_MEMREAD:  begin c.adrsrc = 1'b1; end
            S_MEMWB:    begin c.resultsrc = 2'b01; c.regwrite = 1'b1; end
            S_MEMWRITE: begin c.adrsrc = 1'b1; c.memwrite = 1'b1; end
            S_EXECR:    begin c.srca = 2'b10; c.aluop = 2'b10; end
            S_EXECI:    begin c.srca = 2'b10; c.srcb = 2'b01; c.aluop = 2'b10; end
            S_ALUWB:    begin c.regwrite = 1'b1; end
            S_BEQ:      begin c.srca = 2'b10; c.aluop = 2'b01; c.branch = 1'b1; end
            S_JAL:      begin c.srca = 2'b01; c.srcb = 2'b10; c.pcupdate = 1'b1; end
            default:    c = '0;
        endcase
        return c;
    endfunction

`ifdef CTRL_BNE_EN
    assign branch_ok = (f3 == 3'b000) || (f3 == 3'b001);
    assign taken     = instr[12] ? ~zero1 : zero1;
`else
    assign branch_ok = (f3 == 3'b000);
    assign taken     = zero1;
`endif

    always_comb begin
        bad_instr = 1'b1;
        case (op)
            OP_LW, OP_SW, OP_R, OP_I, OP_JAL: bad_instr = 1'b0;
            OP_B:                             bad_instr = ~branch_ok;
            default:                          bad_instr = 1'b1;
        endcase
    end

    always_comb begin
        nxt = S_FETCH;
        case (cur)
            S_FETCH:  nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_R:         nxt = S_EXECR;
                    OP_I:         nxt = S_EXECI;
                    OP_B:         nxt = branch_ok ? S_BEQ : S_FETCH;
                    OP_JAL:       nxt = S_JAL;
                    default:      nxt = S_FETCH;
                endcase
            end
            // opcode bit 5 separates sw (0100011) from lw (0000011)
            S_MEMADR:   nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  nxt = S_MEMWB;
            S_EXECR:    nxt = S_ALUWB;
            S_EXECI:    nxt = S_ALUWB;
            S_JAL:      nxt = S_ALUWB;
            default:    nxt = S_FETCH;
        endcase
    end

    // Controls are registered alongside the state so they come straight from flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur <= S_FETCH;
            ctl <= ctl_of(S_FETCH);
        end else begin
            cur <= nxt;
            ctl <= ctl_of(nxt);
        end
    end

    always_comb begin
        ALUcontrol = ALU_ADD;
        case (ctl.aluop)
            2'b01: ALUcontrol = ALU_SUB;
            2'b10: begin
                case (f3)
                    3'b000:  ALUcontrol = (op[5] & instr[30]) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUcontrol = ALU_SLT;
                    3'b100:  ALUcontrol = ALU_XOR;
                    3'b110:  ALUcontrol = ALU_OR;
                    3'b111:  ALUcontrol = ALU_AND;
                    3'b001:  ALUcontrol = ALU_SLL;
                    3'b101:  ALUcontrol = instr[30] ? ALU_SRA : ALU_SRL;
                    default: ALUcontrol = ALU_ADD;
                endcase
            end
            default: ALUcontrol = ALU_ADD;
        endcase
    end

    always_comb begin
        immsrc = 2'b00;
        case (op)
            OP_SW:   immsrc = 2'b01;
            OP_B:    immsrc = 2'b10;
            OP_JAL:  immsrc = 2'b11;
            default: immsrc = 2'b00;
        endcase
    end

    // Write enables are gated by reset itself so an abort takes effect in the same cycle.
    assign PCwrite   = ~reset & (ctl.pcupdate | (ctl.branch & taken));
    assign IRwrite   = ~reset & ctl.irwrite;
    assign Memwrite  = ~reset & ctl.memwrite;
    assign Regwrite  = ~reset & ctl.regwrite;
    assign Adrsrc    = ctl.adrsrc;
    assign ALUsrcA   = ctl.srca;
    assign ALUsrcB   = ctl.srcb;
    assign Resultsrc = ctl.resultsrc;
    assign illegal   = (cur == S_DECODE) & bad_instr;
    assign state     = DBG_STATE_W'(cur);

endmodule
